gate_tt_checker: RTL and testbench

//  Upstream stimulus/check stage for a 2-input combinational gate. On start, drives a_o/b_o

---
 rtl/gate_tt_pkg.sv | 20 ++
 rtl/gate_tt_checker.sv | 140 ++++++++++++++
 tb/tb_gate_tt_checker.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_tt_pkg.sv
// Shared definitions for the 2-input gate truth-table self-test:
// FSM state type, reference truth tables and the vector index width.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit i of each table is the gate output for {a,b} == i
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int IDX_W = 2;

endpackage

// File: rtl/gate_tt_checker.sv
// On-chip truth-table checker for a 2-input gate: walks {a,b} through 00..11,
// lets each vector settle, samples y_i against EXP_TT and reports pass/fail.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter logic [3:0] EXP_TT = TT_NAND,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    localparam int CNT_W = (SETTLE >= 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    generate
        if (SETTLE < 1) begin : gBadSettle
            $error("gate_tt_checker: SETTLE must be at least 1");
        end
    endgenerate

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [2:0]       r_errCnt;
    logic [3:0]       r_failMask;

    state_t           w_nextState;
    logic [IDX_W-1:0] w_nextIdx;
    logic [CNT_W-1:0] w_nextCnt;
    logic [1:0]       w_nextVec;
    logic             w_nextBusy;
    logic             w_nextDone;
    logic             w_nextPass;
    logic [2:0]       w_nextErrCnt;
    logic [3:0]       w_nextFailMask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errCnt   <= '0;
            r_failMask <= '0;
        end else begin
            r_state    <= w_nextState;
            r_idx      <= w_nextIdx;
            r_cnt      <= w_nextCnt;
            r_vec      <= w_nextVec;
            r_busy     <= w_nextBusy;
            r_done     <= w_nextDone;
            r_pass     <= w_nextPass;
            r_errCnt   <= w_nextErrCnt;
            r_failMask <= w_nextFailMask;
        end
    end

    // The gate inputs change only on entry to DRIVE, so a vector stays stable
    // for all SETTLE drive cycles plus the sample cycle.
    always_comb begin
        w_nextState    = r_state;
        w_nextIdx      = r_idx;
        w_nextCnt      = r_cnt;
        w_nextVec      = r_vec;
        w_nextBusy     = r_busy;
        w_nextDone     = r_done;
        w_nextPass     = r_pass;
        w_nextErrCnt   = r_errCnt;
        w_nextFailMask = r_failMask;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_nextState    = DRIVE;
                    w_nextIdx      = '0;
                    w_nextCnt      = '0;
                    w_nextVec      = '0;
                    w_nextBusy     = 1'b1;
                    w_nextDone     = 1'b0;
                    w_nextPass     = 1'b0;
                    w_nextErrCnt   = '0;
                    w_nextFailMask = '0;
                end
            end
            DRIVE: begin
                w_nextCnt = r_cnt + 1'b1;
                if (r_cnt == SETTLE_LAST) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                if (y_i != EXP_TT[r_idx]) begin
                    w_nextErrCnt           = r_errCnt + 3'd1;
                    w_nextFailMask[r_idx]  = 1'b1;
                end
                if (r_idx == IDX_LAST) begin
                    w_nextState = DONE;
                    w_nextBusy  = 1'b0;
                    w_nextDone  = 1'b1;
                    w_nextPass  = (w_nextErrCnt == 3'd0);
                end else begin
                    w_nextState = DRIVE;
                    w_nextIdx   = r_idx + 1'b1;
                    w_nextCnt   = '0;
                    w_nextVec   = r_idx + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign a_o       = r_vec[1];
    assign b_o       = r_vec[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_errCnt;
    assign fail_mask = r_failMask;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench for gate_tt_checker: a modelled gate feeds y_i and a
// scoreboard holds the expected vector trace and run results.
module tb_gate_tt_checker;

    localparam int M_NAND   = 0;
    localparam int M_AND    = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_STUCK0 = 3;

    typedef struct packed {
        logic [2:0] errCnt;
        logic [3:0] mask;
        logic       pass;
    } result_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y;
    logic       aO;
    logic       bO;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] errCnt;
    logic [3:0] failMask;

    int         mode = M_NAND;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] traceQ[$];
    result_t    resultQ[$];

    always #5 clk = ~clk;

    gate_tt_checker #(
        .EXP_TT(4'b0111),
        .SETTLE(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y_i      (y),
        .a_o      (aO),
        .b_o      (bO),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (errCnt),
        .fail_mask(failMask)
    );

    function automatic logic gateModel(input int m, input logic a, input logic b);
        case (m)
            M_NAND:   return ~(a & b);
            M_AND:    return a & b;
            M_STUCK1: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    always_comb y = gateModel(mode, aO, bO);

    // Expected trace is {busy,a,b} per busy cycle; results compare against a true NAND.
    task automatic pushExpected();
        result_t r;
        logic [1:0] v;
        r = '0;
        for (int k = 0; k < 12; k++) begin
            v = 2'(k / 3);
            traceQ.push_back({1'b1, v});
        end
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            if (gateModel(mode, v[1], v[0]) !== ~(v[1] & v[0])) begin
                r.errCnt  = r.errCnt + 3'd1;
                r.mask[i] = 1'b1;
            end
        end
        r.pass = (r.errCnt == 3'd0);
        resultQ.push_back(r);
    endtask

    task automatic startRun();
        pushExpected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({aO, bO, busy, done, pass, errCnt, failMask} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected %b",
                     {aO, bO, busy, done, pass, errCnt, failMask}, 11'd0);
        end
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({aO, bO, busy, done, pass, errCnt, failMask} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_with_start: got %b expected %b",
                     {aO, bO, busy, done, pass, errCnt, failMask}, 11'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_truth_tables();
        logic [2:0] e;
        result_t    r;
        for (int m = 0; m < 4; m++) begin
            mode = m;
            startRun();
            for (int k = 1; k <= 12; k++) begin
                e = traceQ.pop_front();
                checks++;
                if ({busy, aO, bO} !== e || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL trace mode%0d cycle%0d: got busy,a,b=%b done=%b expected %b done=0",
                             m, k, {busy, aO, bO}, done, e);
                end
                @(negedge clk);
            end
            r = resultQ.pop_front();
            checks++;
            if ({busy, done, pass, errCnt, failMask} !== {1'b0, 1'b1, r.pass, r.errCnt, r.mask}) begin
                errors++;
                $display("[TB] FAIL result mode%0d: got busy=%b done=%b pass=%b err=%0d mask=%b expected busy=0 done=1 pass=%b err=%0d mask=%b",
                         m, busy, done, pass, errCnt, failMask, r.pass, r.errCnt, r.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        result_t    r;
        for (int run = 0; run < 2; run++) begin
            mode = (run == 0) ? M_NAND : M_STUCK0;
            startRun();
            for (int k = 1; k <= 12; k++) begin
                e = traceQ.pop_front();
                checks++;
                if ({busy, aO, bO} !== e || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_trace run%0d cycle%0d: got busy,a,b=%b done=%b expected %b done=0",
                             run, k, {busy, aO, bO}, done, e);
                end
                start = (run == 0 && (k == 3 || k == 7));
                @(negedge clk);
            end
            start = 1'b0;
            r = resultQ.pop_front();
            checks++;
            if ({busy, done, pass, errCnt, failMask} !== {1'b0, 1'b1, r.pass, r.errCnt, r.mask}) begin
                errors++;
                $display("[TB] FAIL b2b_result run%0d: got busy=%b done=%b pass=%b err=%0d mask=%b expected busy=0 done=1 pass=%b err=%0d mask=%b",
                         run, busy, done, pass, errCnt, failMask, r.pass, r.errCnt, r.mask);
            end
            @(negedge clk);
            checks++;
            if ({done, pass, errCnt, failMask, aO, bO} !== {1'b1, r.pass, r.errCnt, r.mask, 2'b11}) begin
                errors++;
                $display("[TB] FAIL b2b_hold run%0d: got done=%b pass=%b err=%0d mask=%b ab=%b%b expected done=1 pass=%b err=%0d mask=%b ab=11",
                         run, done, pass, errCnt, failMask, aO, bO, r.pass, r.errCnt, r.mask);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [2:0] e;
        result_t    r;
        mode = M_NAND;
        startRun();
        for (int k = 1; k <= 5; k++) begin
            e = traceQ.pop_front();
            checks++;
            if ({busy, aO, bO} !== e) begin
                errors++;
                $display("[TB] FAIL abort_trace cycle%0d: got %b expected %b", k, {busy, aO, bO}, e);
            end
            if (k == 5) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        traceQ.delete();
        resultQ.delete();
        checks++;
        if ({aO, bO, busy, done, pass, errCnt, failMask} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_clear: got %b expected %b",
                     {aO, bO, busy, done, pass, errCnt, failMask}, 11'd0);
        end
        startRun();
        for (int k = 1; k <= 12; k++) begin
            e = traceQ.pop_front();
            checks++;
            if ({busy, aO, bO} !== e || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rerun_trace cycle%0d: got busy,a,b=%b done=%b expected %b done=0",
                         k, {busy, aO, bO}, done, e);
            end
            @(negedge clk);
        end
        r = resultQ.pop_front();
        checks++;
        if ({busy, done, pass, errCnt, failMask} !== {1'b0, 1'b1, r.pass, r.errCnt, r.mask}) begin
            errors++;
            $display("[TB] FAIL rerun_result: got busy=%b done=%b pass=%b err=%0d mask=%b expected busy=0 done=1 pass=%b err=%0d mask=%b",
                     busy, done, pass, errCnt, failMask, r.pass, r.errCnt, r.mask);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        test_reset();
        test_truth_tables();
        test_back_to_back();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
